// File: rtl/aes_enc_iter.sv
// Iterative AES block cipher: one round per clock, round keys requested by index from aes_kexp.
// Optional macro AES_DEC_EN adds a 'dec' input selecting the inverse cipher.
module aes_enc_iter #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   SBox [0:255],
    input  logic [7:0]   IBox [0:255],
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef AES_DEC_EN
    input  logic         dec,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int          NR   = NK + 6;
    localparam logic [3:0]  NR_L = 4'(NR);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
        $error("aes_enc_iter: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         dec_q, dec_d;

    logic         dec_in_s;
    logic         last_s;
    logic [7:0]   sb_s [16];
    logic [127:0] sr_s;
    logic [127:0] mc_s;
    logic [127:0] enc_s;
    logic [127:0] round_s;

    assign last_s = (rnd_q == NR_L);

    // Forward round: SubBytes fused with ShiftRows by gathering from the shifted source byte
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb_s[i] = SBox[st_q[127 - 8*i -: 8]];
        end
        sr_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sr_s[127 - 8*i -: 8] = sb_s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        end
        mc_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mc_s[127 - 32*c -: 32] = mix_col(sr_s[127 - 32*c -: 32]);
        end
        enc_s = (last_s ? sr_s : mc_s) ^ rk_data;
    end

`ifdef AES_DEC_EN
    function automatic logic [7:0] gf_mul_k(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        case (k)
            4'd9:    return a8 ^ a;
            4'd11:   return a8 ^ a2 ^ a;
            4'd13:   return a8 ^ a4 ^ a;
            4'd14:   return a8 ^ a4 ^ a2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul_k(a0, 4'd14) ^ gf_mul_k(a1, 4'd11) ^ gf_mul_k(a2, 4'd13) ^ gf_mul_k(a3, 4'd9),
                gf_mul_k(a0, 4'd9)  ^ gf_mul_k(a1, 4'd14) ^ gf_mul_k(a2, 4'd11) ^ gf_mul_k(a3, 4'd13),
                gf_mul_k(a0, 4'd13) ^ gf_mul_k(a1, 4'd9)  ^ gf_mul_k(a2, 4'd14) ^ gf_mul_k(a3, 4'd11),
                gf_mul_k(a0, 4'd11) ^ gf_mul_k(a1, 4'd13) ^ gf_mul_k(a2, 4'd9)  ^ gf_mul_k(a3, 4'd14)};
    endfunction

    logic [7:0]   ib_s [16];
    logic [127:0] ark_s;
    logic [127:0] imc_s;
    logic [127:0] dec_s;

    assign dec_in_s = dec;

    // Inverse round: InvShiftRows gather, InvSubBytes, AddRoundKey, then InvMixColumns
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ib_s[i] = IBox[st_q[127 - 8*((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)) -: 8]];
        end
        ark_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            ark_s[127 - 8*i -: 8] = ib_s[i] ^ rk_data[127 - 8*i -: 8];
        end
        imc_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            imc_s[127 - 32*c -: 32] = inv_mix_col(ark_s[127 - 32*c -: 32]);
        end
        dec_s = last_s ? ark_s : imc_s;
    end

    assign round_s = dec_q ? dec_s : enc_s;
`else
    logic unused_ibox_s;

    assign dec_in_s = 1'b0;
    assign round_s  = enc_s;

    // Without the inverse cipher the inverse table is only folded into a sink
    always_comb begin
        unused_ibox_s = 1'b0;
        for (int i = 0; i < 256; i++) begin
            unused_ibox_s = unused_ibox_s ^ (^IBox[i]);
        end
    end
`endif

    // Next-state logic; rk_idx_d always points at the key the following cycle consumes
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        rk_idx_d    = rk_idx_q;
        dec_d       = dec_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d       = in_data ^ rk_data;
                    rnd_d      = 4'd1;
                    dec_d      = dec_in_s;
                    rk_idx_d   = dec_in_s ? (NR_L - 4'd1) : 4'd1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    fsm_d      = S_ROUND;
                end else begin
                    rk_idx_d   = 4'd0;
                end
            end
            S_ROUND: begin
                st_d  = round_s;
                rnd_d = rnd_q + 4'd1;
                if (last_s) begin
                    out_data_d  = round_s;
                    out_valid_d = 1'b1;
                    rnd_d       = 4'd0;
                    rk_idx_d    = 4'd0;
                    fsm_d       = S_DONE;
                end else begin
                    rk_idx_d    = dec_q ? (NR_L - rnd_q - 4'd1) : (rnd_q + 4'd1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                fsm_d       = S_IDLE;
                rnd_d       = 4'd0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                rk_idx_d    = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            rnd_q       <= 4'd0;
            st_q        <= 128'h0;
            out_data_q  <= 128'h0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rk_idx_q    <= 4'd0;
            dec_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            rk_idx_q    <= rk_idx_d;
            dec_q       <= dec_d;
        end
    end

    // The inverse cipher's first AddRoundKey needs key NR before the handshake registers anything
    assign rk_idx    = (fsm_q == S_IDLE && dec_in_s) ? NR_L : rk_idx_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: NK=4 and NK=8 instances, key schedule and AES reference model in the bench.
module tb_aes_enc_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]   sbox_t [0:255];
    logic [7:0]   ibox_t [0:255];
    logic [127:0] rk4 [0:15];
    logic [127:0] rk8 [0:15];

    logic         sel_s       = 1'b0;
    logic         in_valid_s  = 1'b0;
    logic         out_ready_s = 1'b0;
    logic [127:0] in_data_s   = 128'h0;
`ifdef AES_DEC_EN
    logic         dec_drv     = 1'b0;
`endif

    logic [3:0]   rk_idx4, rk_idx8;
    logic [127:0] rk_data4, rk_data8;
    logic         in_valid4, in_valid8, in_ready4, in_ready8;
    logic         out_valid4, out_valid8, out_ready4, out_ready8;
    logic [127:0] out_data4, out_data8;
    logic         busy4, busy8;

    assign rk_data4   = rk4[rk_idx4];
    assign rk_data8   = rk8[rk_idx8];
    assign in_valid4  = in_valid_s & ~sel_s;
    assign in_valid8  = in_valid_s & sel_s;
    assign out_ready4 = out_ready_s & ~sel_s;
    assign out_ready8 = out_ready_s & sel_s;

    logic         cur_in_ready, cur_out_valid, cur_busy;
    logic [127:0] cur_out_data;
    logic [3:0]   cur_rk_idx;
    assign cur_in_ready  = sel_s ? in_ready8  : in_ready4;
    assign cur_out_valid = sel_s ? out_valid8 : out_valid4;
    assign cur_busy      = sel_s ? busy8      : busy4;
    assign cur_out_data  = sel_s ? out_data8  : out_data4;
    assign cur_rk_idx    = sel_s ? rk_idx8    : rk_idx4;

    aes_enc_iter #(.NK(4)) dut4 (
        .clk(clk), .rst(rst), .SBox(sbox_t), .IBox(ibox_t),
        .rk_idx(rk_idx4), .rk_data(rk_data4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data_s),
`ifdef AES_DEC_EN
        .dec(dec_drv),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
    );

    aes_enc_iter #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .SBox(sbox_t), .IBox(ibox_t),
        .rk_idx(rk_idx8), .rk_data(rk_data8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data_s),
`ifdef AES_DEC_EN
        .dec(1'b0),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) ibox_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input int nk, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 4) rk4[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk8[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] model_cipher(input logic [127:0] blk, input bit use8, input bit inv);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [127:0] k, res;
        logic [7:0]   acc;
        int nr;
        nr = use8 ? 14 : 10;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        k = use8 ? rk8[inv ? nr : 0] : rk4[inv ? nr : 0];
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            if (!inv) begin
                for (int row = 0; row < 4; row++)
                    for (int c = 0; c < 4; c++)
                        t[row + 4*c] = sbox_t[s[row + 4*((c + row) % 4)]];
            end else begin
                for (int row = 0; row < 4; row++)
                    for (int c = 0; c < 4; c++)
                        t[row + 4*((c + row) % 4)] = ibox_t[s[row + 4*c]];
            end
            k = use8 ? rk8[inv ? nr - r : r] : rk4[inv ? nr - r : r];
            if (inv) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127 - 8*i -: 8];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    if (r == nr) begin
                        acc = t[row + 4*c];
                    end else begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row + 4) % 4], t[j + 4*c]);
                    end
                    s[row + 4*c] = inv ? acc : (acc ^ k[127 - 8*(row + 4*c) -: 8]);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic run_block(input bit use8, input logic [127:0] din, output logic [127:0] dout, output int lat);
        sel_s = use8;
        @(negedge clk);
        in_data_s  = din;
        in_valid_s = 1'b1;
        vectors++;
        if (cur_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_before_accept: got %b expected 1", cur_in_ready);
        end
        @(negedge clk);
        in_valid_s = 1'b0;
        lat = 0;
        while (cur_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        dout = cur_out_data;
        out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (in_ready4 !== 1'b1)   begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready4); end
        vectors++; if (out_valid4 !== 1'b0)  begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4); end
        vectors++; if (out_data4 !== 128'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data4); end
        vectors++; if (busy4 !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy4); end
        vectors++; if (rk_idx4 !== 4'd0)     begin miscompares++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx4); end
        vectors++; if (busy8 !== 1'b0 || in_ready8 !== 1'b1) begin miscompares++; $display("FAIL reset_nk8: got busy %b in_ready %b expected 0 1", busy8, in_ready8); end
        rst = 1'b0;
    endtask

    task automatic test_known_vectors();
        logic [127:0] ct;
        int lat;
        expand_key(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        run_block(1'b0, 128'h3243f6a8885a308d313198a2e0370734, ct, lat);
        vectors++; if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin miscompares++; $display("FAIL fips_b_ct: got %h expected 3925841d02dc09fbdc118597196a0b32", ct); end
        vectors++; if (lat != 10) begin miscompares++; $display("FAIL fips_b_latency: got %0d expected 10", lat); end
        expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        run_block(1'b0, 128'h00112233445566778899aabbccddeeff, ct, lat);
        vectors++; if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin miscompares++; $display("FAIL aes128_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
        expand_key(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        run_block(1'b1, 128'h00112233445566778899aabbccddeeff, ct, lat);
        vectors++; if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin miscompares++; $display("FAIL aes256_ct: got %h expected 8ea2b7ca516745bfeafc49904b496089", ct); end
        vectors++; if (lat != 14) begin miscompares++; $display("FAIL aes256_latency: got %0d expected 14", lat); end
    endtask

    task automatic test_random();
        logic [127:0] pt, ct, exp_ct;
        logic [255:0] key;
        bit use8;
        int lat;
        for (int n = 0; n < 8; n++) begin
            use8 = 1'($urandom_range(0, 1));
            key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt   = {$urandom, $urandom, $urandom, $urandom};
            expand_key(use8 ? 8 : 4, use8 ? key : {key[255:128], 128'h0});
            exp_ct = model_cipher(pt, use8, 1'b0);
            run_block(use8, pt, ct, lat);
            vectors++; if (ct !== exp_ct) begin miscompares++; $display("FAIL random_ct[%0d]: got %h expected %h", n, ct, exp_ct); end
            vectors++; if (lat != (use8 ? 14 : 10)) begin miscompares++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, lat, use8 ? 14 : 10); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, pt2, exp1, exp2;
        int n;
        pt1 = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        exp1 = model_cipher(pt1, 1'b0, 1'b0);
        exp2 = model_cipher(pt2, 1'b0, 1'b0);
        sel_s = 1'b0;
        @(negedge clk);
        in_data_s  = pt1;
        in_valid_s = 1'b1;
        @(negedge clk);
        in_data_s  = pt2;
        n = 0;
        while (out_valid4 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        vectors++; if (out_data4 !== exp1) begin miscompares++; $display("FAIL bp_first_ct: got %h expected %h", out_data4, exp1); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid4 !== 1'b1 || out_data4 !== exp1 || in_ready4 !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid %b ready %b data %h expected 1 0 %h", c, out_valid4, in_ready4, out_data4, exp1);
            end
        end
        out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_s = 1'b0;
        vectors++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_after_out_hs: got valid %b ready %b busy %b expected 0 1 0", out_valid4, in_ready4, busy4);
        end
        @(negedge clk);
        in_valid_s = 1'b0;
        vectors++;
        if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_second_accept: got busy %b ready %b expected 1 0", busy4, in_ready4);
        end
        n = 0;
        while (out_valid4 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        vectors++; if (n != 10) begin miscompares++; $display("FAIL bp_second_latency: got %0d expected 10", n); end
        vectors++; if (out_data4 !== exp2) begin miscompares++; $display("FAIL bp_second_ct: got %h expected %h", out_data4, exp2); end
        out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_s = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat, seen;
        expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        sel_s = 1'b0;
        @(negedge clk);
        in_data_s  = 128'h00112233445566778899aabbccddeeff;
        in_valid_s = 1'b1;
        @(negedge clk);
        in_valid_s = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (rk_idx4 !== 4'd5) begin miscompares++; $display("FAIL mid_round_idx: got %0d expected 5", rk_idx4); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy4 !== 1'b0 || in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_data4 !== 128'h0 || rk_idx4 !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got busy %b ready %b valid %b idx %0d data %h expected 0 1 0 0 0", busy4, in_ready4, out_valid4, rk_idx4, out_data4);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid4 === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL mid_reset_no_output: got %0d valid cycles expected 0", seen); end
        run_block(1'b0, 128'h00112233445566778899aabbccddeeff, ct, lat);
        vectors++; if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin miscompares++; $display("FAIL mid_reset_recover: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
    endtask

`ifdef AES_DEC_EN
    task automatic test_decrypt();
        logic [127:0] pt, ct, got;
        int lat;
        expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        dec_drv = 1'b1;
        run_block(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, got, lat);
        vectors++; if (got !== 128'h00112233445566778899aabbccddeeff) begin miscompares++; $display("FAIL dec_known: got %h expected 00112233445566778899aabbccddeeff", got); end
        vectors++; if (lat != 10) begin miscompares++; $display("FAIL dec_latency: got %0d expected 10", lat); end
        for (int n = 0; n < 4; n++) begin
            expand_key(4, {$urandom, $urandom, $urandom, $urandom, 128'h0});
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = model_cipher(pt, 1'b0, 1'b0);
            run_block(1'b0, ct, got, lat);
            vectors++; if (got !== pt) begin miscompares++; $display("FAIL dec_random[%0d]: got %h expected %h", n, got, pt); end
        end
        dec_drv = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) begin
            rk4[i] = 128'h0;
            rk8[i] = 128'h0;
        end
        build_sbox();
        test_reset();
        test_known_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_DEC_EN
        test_decrypt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
